// File: rtl/moore_seq_pkg.sv
// Shared definitions for the 2-bit Moore cycle generator and its checker.
// Cycle constants, lock-state encoding and the successor/output rules.
package moore_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    localparam logic [1:0] ST0 = 2'b00;
    localparam logic [1:0] ST1 = 2'b01;
    localparam logic [1:0] ST2 = 2'b10;
    localparam logic [1:0] ST3 = 2'b11;

    function automatic logic [1:0] next_state(input logic [1:0] s);
        return s + 2'd1;
    endfunction

    function automatic logic expected_out(input logic [1:0] s);
        return (s == ST3);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared only by rst.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/moore_seq_checker.sv
// Protocol monitor for the 00->01->10->11 Moore generator: tracks lock,
// flags errors seen while locked and counts completed cycles.
module moore_seq_checker
    import moore_seq_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8,
    parameter int WRAP_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        state_in,
    input  logic              out_in,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [1:0]        expected_state
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_COUNT);

    lock_state_e      lock_q, lock_d;
    logic [1:0]       ref_q, ref_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             locked_q;
    logic             err_pulse_q;
    logic             sample_valid;
    logic             err_inc;
    logic             wrap_inc;

    assign sample_valid = (state_in == next_state(ref_q)) &&
                          (out_in == expected_out(state_in));

    always_comb begin
        lock_d   = lock_q;
        ref_d    = ref_q;
        run_d    = run_q;
        err_inc  = 1'b0;
        wrap_inc = 1'b0;
        // Disabling wins over any mismatch: no error, no wrap, reference kept.
        if (!enable) begin
            lock_d = IDLE;
            run_d  = '0;
        end else begin
            case (lock_q)
                IDLE: begin
                    ref_d  = state_in;
                    run_d  = '0;
                    lock_d = SEARCH;
                end
                SEARCH: begin
                    ref_d = state_in;
                    if (!sample_valid) begin
                        run_d = '0;
                    end else if (run_q + RUN_W'(1) == LOCK_RUN) begin
                        run_d  = LOCK_RUN;
                        lock_d = LOCKED;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
                LOCKED: begin
                    ref_d = state_in;
                    if (sample_valid) begin
                        wrap_inc = (ref_q == ST3);
                    end else begin
                        err_inc = 1'b1;
                        run_d   = '0;
                        lock_d  = SEARCH;
                    end
                end
                default: begin
                    lock_d = IDLE;
                    run_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q      <= IDLE;
            ref_q       <= ST0;
            run_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            ref_q       <= ref_d;
            run_q       <= run_d;
            locked_q    <= (lock_d == LOCKED);
            err_pulse_q <= err_inc;
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_inc),
        .cnt (err_count)
    );

    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk (clk),
        .rst (rst),
        .inc (wrap_inc),
        .cnt (wrap_count)
    );

    assign locked         = locked_q;
    assign err_pulse      = err_pulse_q;
    assign expected_state = next_state(ref_q);

endmodule

// File: tb/tb_moore_seq_checker.sv
// Directed + randomized bench for moore_seq_checker against a count-based
// reference model; a narrow-counter instance exercises saturation.
module tb_moore_seq_checker;

    localparam int LC = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0;
    logic [1:0]  st_i = 2'b00;
    logic        out_i = 1'b0;

    logic        locked_a, pulse_a, locked_b, pulse_b;
    logic [7:0]  err_a;
    logic [15:0] wrap_a;
    logic [1:0]  err_b;
    logic [2:0]  wrap_b;
    logic [1:0]  exp_a, exp_b;

    int checks = 0;
    int failures = 0;

    // Reference model: a run length of valid samples since the last capture.
    bit m_have_ref;
    int m_ref, m_run, m_errs, m_wraps;
    bit m_pulse;
    int gen_s = 0;
    int step_no = 0;

    always #5 clk = ~clk;

    moore_seq_checker #(.LOCK_COUNT(LC), .ERR_W(8), .WRAP_W(16)) dut (
        .clk(clk), .rst(rst_i), .enable(en_i), .state_in(st_i), .out_in(out_i),
        .locked(locked_a), .err_pulse(pulse_a), .err_count(err_a),
        .wrap_count(wrap_a), .expected_state(exp_a)
    );

    moore_seq_checker #(.LOCK_COUNT(LC), .ERR_W(2), .WRAP_W(3)) dut_w2 (
        .clk(clk), .rst(rst_i), .enable(en_i), .state_in(st_i), .out_in(out_i),
        .locked(locked_b), .err_pulse(pulse_b), .err_count(err_b),
        .wrap_count(wrap_b), .expected_state(exp_b)
    );

    function automatic int sat(input int v, input int w);
        int top;
        top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, expv);
        end
    endtask

    task automatic model(input bit r, input bit en, input int s, input bit o);
        bit valid, was_locked;
        m_pulse = 1'b0;
        if (r) begin
            m_have_ref = 1'b0; m_ref = 0; m_run = 0; m_errs = 0; m_wraps = 0;
        end else if (!en) begin
            m_have_ref = 1'b0; m_run = 0;
        end else if (!m_have_ref) begin
            m_have_ref = 1'b1; m_ref = s; m_run = 0;
        end else begin
            valid = (s == (m_ref + 1) % 4) && (o == (s == 3));
            was_locked = (m_run >= LC);
            if (valid) begin
                if (was_locked && m_ref == 3) m_wraps++;
                m_run++;
            end else begin
                if (was_locked) begin
                    m_errs++;
                    m_pulse = 1'b1;
                end
                m_run = 0;
            end
            m_ref = s;
        end
    endtask

    task automatic step(input bit r, input bit en, input int s, input bit o);
        bit exp_locked;
        rst_i = r; en_i = en; st_i = 2'(s); out_i = o;
        @(posedge clk);
        #1;
        step_no++;
        model(r, en, s, o);
        exp_locked = m_have_ref && (m_run >= LC);
        chk("locked",       32'(locked_a), 32'(exp_locked));
        chk("err_pulse",    32'(pulse_a),  32'(m_pulse));
        chk("err_count",    32'(err_a),    32'(sat(m_errs, 8)));
        chk("wrap_count",   32'(wrap_a),   32'(sat(m_wraps, 16)));
        chk("exp_state",    32'(exp_a),    32'((m_ref + 1) % 4));
        chk("err_pulse_w2", 32'(pulse_b),  32'(m_pulse));
        chk("err_count_w2", 32'(err_b),    32'(sat(m_errs, 2)));
        chk("wrap_count_w2",32'(wrap_b),   32'(sat(m_wraps, 3)));
        $display("step %0d rst=%0b en=%0b st=%0d out=%0b -> locked=%0b pulse=%0b errs=%0d wraps=%0d exp=%0d",
                 step_no, r, en, s, o, locked_a, pulse_a, err_a, wrap_a, exp_a);
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, gen_s, gen_s == 3);
            gen_s = (gen_s + 1) % 4;
        end
    endtask

    // kind 0: skip one state, 1: repeat previous state, 2: wrong out bit.
    task automatic inject(input int kind);
        int s;
        case (kind)
            0: begin
                s = (gen_s + 1) % 4;
                step(1'b0, 1'b1, s, s == 3);
                gen_s = (gen_s + 2) % 4;
            end
            1: begin
                s = (gen_s + 3) % 4;
                step(1'b0, 1'b1, s, s == 3);
            end
            default: begin
                step(1'b0, 1'b1, gen_s, gen_s != 3);
                gen_s = (gen_s + 1) % 4;
            end
        endcase
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 4 && gen_s != target; i++) clean(1);
    endtask

    initial begin
        int roll;
        // Reset and reset values.
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
        gen_s = 0;
        // Clean stream from reset release: lock after edge 5, wraps every 4.
        clean(22);
        // Skip 01->11 while locked, then relock.
        run_until(2);
        inject(0);
        clean(10);
        // Wrong out at state 10.
        run_until(2);
        inject(2);
        clean(10);
        // Generator stuck in reset: constant 00/0.
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 0, 1'b0);
        gen_s = 1;
        clean(8);
        // Six errors, each followed by relock; narrow counter saturates at 3.
        for (int i = 0; i < 6; i++) begin
            inject(int'($urandom_range(2)));
            clean(7);
        end
        // rst while locked.
        step(1'b1, 1'b1, gen_s, gen_s == 3);
        gen_s = 0;
        clean(9);
        // Enable dropped on a mismatch edge.
        step(1'b0, 1'b0, (gen_s + 2) % 4, 1'b1);
        step(1'b0, 1'b0, gen_s, 1'b0);
        clean(12);
        // Randomized mix of clean cycles, faults, disables and resets.
        for (int i = 0; i < 400; i++) begin
            roll = int'($urandom_range(99));
            if (roll < 2) begin
                step(1'b1, 1'($urandom_range(1)), gen_s, gen_s == 3);
            end else if (roll < 6) begin
                step(1'b0, 1'b0, int'($urandom_range(3)), 1'($urandom_range(1)));
            end else if (roll < 14) begin
                inject(int'($urandom_range(2)));
            end else if (roll < 16) begin
                step(1'b0, 1'b1, int'($urandom_range(3)), 1'($urandom_range(1)));
                gen_s = int'($urandom_range(3));
            end else begin
                clean(1);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
